// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: shift-add multiplier and restoring divider sharing one
// step counter. Each op takes WIDTH steps plus one sign-fix edge before a one-cycle ready pulse.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
        mag_of = v[WIDTH-1] ? (-v) : v;
    endfunction

    logic [2:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               sign_r;
    logic               div_r;
    logic               divzero_r;

    logic               accept_s;
    logic               start_div_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top_s;
    logic               mul_exc_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   fix_result_s;
    logic               fix_exc_s;

    assign accept_s    = ((state_r == S_IDLE) || (state_r == S_DONE)) && (ctrl_MULT || ctrl_DIV);
    assign start_div_s = ctrl_DIV && !ctrl_MULT;
    assign mag_a_s     = mag_of(data_operandA);
    assign mag_b_s     = mag_of(data_operandB);

    assign mul_sum_s   = lo_r[0] ? ({1'b0, hi_r} + {1'b0, mcand_r}) : {1'b0, hi_r};
    assign div_shift_s = {hi_r, lo_r[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, mcand_r};

    assign prod_s      = sign_r ? (-{hi_r, lo_r}) : {hi_r, lo_r};
    assign prod_top_s  = prod_s[2*WIDTH-1:WIDTH-1];
    assign mul_exc_s   = !((&prod_top_s) || !(|prod_top_s));
    assign quot_s      = sign_r ? (-lo_r) : lo_r;

    // Final signed result and exception, selected by operation type.
    always_comb begin
        fix_result_s = {WIDTH{1'b0}};
        fix_exc_s    = 1'b0;
        if (div_r) begin
            if (divzero_r) begin
                fix_result_s = {WIDTH{1'b0}};
                fix_exc_s    = 1'b1;
            end else begin
                // Only -2^(W-1) / -1 yields a positive quotient with the top bit set.
                fix_result_s = quot_s;
                fix_exc_s    = !sign_r && lo_r[WIDTH-1];
            end
        end else begin
            fix_result_s = prod_s[WIDTH-1:0];
            fix_exc_s    = mul_exc_s;
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= S_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            hi_r           <= {WIDTH{1'b0}};
            lo_r           <= {WIDTH{1'b0}};
            mcand_r        <= {WIDTH{1'b0}};
            sign_r         <= 1'b0;
            div_r          <= 1'b0;
            divzero_r      <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        state_r        <= start_div_s ? S_DIV : S_MUL;
                        cnt_r          <= {CNT_W{1'b0}};
                        hi_r           <= {WIDTH{1'b0}};
                        lo_r           <= start_div_s ? mag_a_s : mag_b_s;
                        mcand_r        <= start_div_s ? mag_b_s : mag_a_s;
                        sign_r         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_r          <= start_div_s;
                        divzero_r      <= (data_operandB == {WIDTH{1'b0}});
                        data_exception <= 1'b0;
                        busy           <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MUL: begin
                    hi_r  <= mul_sum_s[WIDTH:1];
                    lo_r  <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_MUL;
                    end
                end
                S_DIV: begin
                    if (!div_trial_s[WIDTH]) begin
                        hi_r <= div_trial_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_r <= div_shift_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_DIV;
                    end
                end
                S_FIX: begin
                    data_result    <= fix_result_s;
                    data_exception <= fix_exc_s;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state_r        <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
